// File: rtl/pulse_meas_pkg.sv
// Shared types and helpers for the pulse measurement block.
package pulse_meas_pkg;

   typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

   // Wide enough for a CW+1 bit difference with any CW up to 32.
   localparam int ABS_W = 33;

   function automatic logic [ABS_W-1:0] absdiff(input logic [ABS_W-1:0] a,
                                                input logic [ABS_W-1:0] b);
      return (a >= b) ? (a - b) : (b - a);
   endfunction

endpackage

// File: rtl/pulse_meas_sync_edge.sv
// Two-flop synchronizer plus a delay flop, producing the synchronized level and its edges.
module sync_edge (
   input  logic clk,
   input  logic d,
   output logic level,
   output logic rise,
   output logic fall
);

   logic s1, s2, s3;

   // The flops carry no reset, so a level held through reset does not produce a false edge.
   always_ff @(posedge clk) begin
      s1 <= d;
      s2 <= s1;
      s3 <= s2;
   end

   assign level = s2;
   assign rise  = s2 & ~s3;
   assign fall  = ~s2 & s3;

endmodule

// File: rtl/pulse_meas.sv
// Measures high/low time of an asynchronous waveform in clk cycles, checks tolerance, flags stuck and lock.
module pulse_meas
   import pulse_meas_pkg::*;
#(
   parameter int CW       = 16,
   parameter int EXP_TON  = 5,
   parameter int EXP_TOFF = 5,
   parameter int TOL      = 1,
   parameter int TIMEOUT  = 1000,
   parameter int LOCK_N   = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic          sig_in,
   output logic [CW-1:0] ton,
   output logic [CW-1:0] toff,
   output logic          meas_valid,
   output logic          err_ton,
   output logic          err_toff,
   output logic          stuck,
   output logic          lock
);

   localparam int               GW         = $clog2(LOCK_N + 1);
   localparam logic [CW-1:0]    TMO_C      = CW'(TIMEOUT);
   localparam logic [CW-1:0]    CNT_MAX    = {CW{1'b1}};
   localparam logic [ABS_W-1:0] EXP_TON_X  = ABS_W'(EXP_TON);
   localparam logic [ABS_W-1:0] EXP_TOFF_X = ABS_W'(EXP_TOFF);
   localparam logic [ABS_W-1:0] TOL_X      = ABS_W'(TOL);
   localparam logic [GW-1:0]    LOCK_C     = GW'(LOCK_N);

   function automatic logic [ABS_W-1:0] widen(input logic [CW-1:0] v);
      return {{(ABS_W-CW){1'b0}}, v};
   endfunction

   logic          sig_lvl, rise, fall;
   state_t        state, state_nxt;
   logic [CW-1:0] cnt, ton_hold;
   logic [GW-1:0] good_cnt;
   logic          start, fall_cap, meas, tmo;
   logic          err_ton_c, err_toff_c;

   sync_edge u_sync (
      .clk   (clk),
      .d     (sig_in),
      .level (sig_lvl),
      .rise  (rise),
      .fall  (fall)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // In LOW the previous sample was low, so a high level is the rising edge.
   always_comb begin
      state_nxt = state;
      start     = 1'b0;
      fall_cap  = 1'b0;
      meas      = 1'b0;
      tmo       = 1'b0;
      if (!en) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE: if (rise) begin
               state_nxt = HIGH;
               start     = 1'b1;
            end
            HIGH: if (cnt == TMO_C) begin
               state_nxt = IDLE;
               tmo       = 1'b1;
            end else if (fall) begin
               state_nxt = LOW;
               fall_cap  = 1'b1;
            end
            LOW: if (cnt == TMO_C) begin
               state_nxt = IDLE;
               tmo       = 1'b1;
            end else if (sig_lvl) begin
               state_nxt = HIGH;
               meas      = 1'b1;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   assign err_ton_c  = absdiff(widen(ton_hold), EXP_TON_X) > TOL_X;
   assign err_toff_c = absdiff(widen(cnt), EXP_TOFF_X) > TOL_X;

   always_ff @(posedge clk) begin
      if (fall_cap) ton_hold <= cnt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt        <= '0;
         ton        <= '0;
         toff       <= '0;
         meas_valid <= 1'b0;
         err_ton    <= 1'b0;
         err_toff   <= 1'b0;
         stuck      <= 1'b0;
         good_cnt   <= '0;
         lock       <= 1'b0;
      end else begin
         meas_valid <= meas;
         if (!en) begin
            cnt      <= '0;
            good_cnt <= '0;
            lock     <= 1'b0;
            stuck    <= 1'b0;
         end else if (tmo) begin
            cnt      <= '0;
            stuck    <= 1'b1;
            good_cnt <= '0;
            lock     <= 1'b0;
         end else if (start) begin
            cnt   <= CW'(1);
            stuck <= 1'b0;
         end else if (fall_cap) begin
            cnt <= CW'(1);
         end else if (meas) begin
            cnt      <= CW'(1);
            ton      <= ton_hold;
            toff     <= cnt;
            err_ton  <= err_ton_c;
            err_toff <= err_toff_c;
            // An erroring period drops lock in the same update that reports it.
            if (err_ton_c || err_toff_c) begin
               good_cnt <= '0;
               lock     <= 1'b0;
            end else if (good_cnt != LOCK_C) begin
               good_cnt <= good_cnt + 1'b1;
               lock     <= ((good_cnt + 1'b1) == LOCK_C);
            end
         end else if (state != IDLE && cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule
